mc_ctrl_fsm: RTL and testbench

Parametrised multicycle RV32I control unit; next generation of the multicycle core's controller. Drives the existing datapath enables and muxes, and adds variable-latency memory support through a MemReq/MemRdy handshake. Adds BNE, LUI, illegal-opcode trap and a retired-instruction counter. Sits beside the datapath in the multicycle top and replaces the fixed-timing control unit.

---
 rtl/mc_ctrl_fsm.sv | 219 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multicycle RV32I control unit with a MemReq/MemRdy memory
// handshake, BNE/LUI support, an illegal-opcode trap and a retired-instruction
// counter.
// Optional build macro: MC_MEM_TIMEOUT_EN bounds every memory wait to
// MEM_TIMEOUT cycles and traps with cause 10 when the bound expires.
module mc_ctrl_fsm #(
  parameter int ALUCTRL_W   = 3,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 MemRdy,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Trap,
  output logic [1:0]           TrapCause,
  output logic [CNT_W-1:0]     InstRet
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t     state;
  logic [2:0] exec_alu;
  logic       exec_ok;
  logic       br_ok;
  logic       br_take;
  logic       mem_wait;
  logic       timeout;
  logic [2:0] alu3;

  // ALU operation for EXECR/EXECI from funct3; unsupported funct3 flags illegal.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    exec_ok  = 1'b1;
    exec_alu = ALU_ADD;
    case (funct3)
      3'b000:  exec_alu = (state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  exec_alu = ALU_SLT;
      3'b100:  exec_alu = ALU_XOR;
      3'b110:  exec_alu = ALU_OR;
      3'b111:  exec_alu = ALU_AND;
      default: exec_ok  = 1'b0;
    endcase
  end

  assign br_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign br_take  = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
  assign mem_wait = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE)
                    && !MemRdy;

`ifdef MC_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // Wait counter idles at zero outside a stall, so it is already clear on
  // entry to any memory state and counts only stalled request cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          wait_cnt <= '0;
    else if (mem_wait) wait_cnt <= wait_cnt + 1'b1;
    else               wait_cnt <= '0;
  end

  // Expires on the stalled cycle that brings the count to MEM_TIMEOUT;
  // a MemRdy in that cycle clears mem_wait and therefore wins.
  assign timeout = mem_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // State sequencing, sticky trap capture and retired-instruction counting.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      Trap      <= 1'b0;
      TrapCause <= 2'b00;
      InstRet   <= '0;
    end else begin
      case (state)
        S_FETCH:
          if (MemRdy) state <= S_DECODE;
          else if (timeout) begin
            state <= S_TRAP; Trap <= 1'b1; TrapCause <= CAUSE_TIMEOUT;
          end
        S_DECODE:
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXECR;
            OP_I:              state <= S_EXECI;
            OP_BR:             state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_LUI:            state <= S_LUI;
            default: begin
              state <= S_TRAP; Trap <= 1'b1; TrapCause <= CAUSE_ILLEGAL;
            end
          endcase
        S_MEMADR: state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:
          if (MemRdy) state <= S_MEMWB;
          else if (timeout) begin
            state <= S_TRAP; Trap <= 1'b1; TrapCause <= CAUSE_TIMEOUT;
          end
        S_MEMWRITE:
          if (MemRdy) begin
            state <= S_FETCH; InstRet <= InstRet + 1'b1;
          end else if (timeout) begin
            state <= S_TRAP; Trap <= 1'b1; TrapCause <= CAUSE_TIMEOUT;
          end
        S_MEMWB, S_ALUWB: begin
          state <= S_FETCH; InstRet <= InstRet + 1'b1;
        end
        S_EXECR, S_EXECI:
          if (exec_ok) state <= S_ALUWB;
          else begin
            state <= S_TRAP; Trap <= 1'b1; TrapCause <= CAUSE_ILLEGAL;
          end
        S_BRANCH:
          if (br_ok) begin
            state <= S_FETCH; InstRet <= InstRet + 1'b1;
          end else begin
            state <= S_TRAP; Trap <= 1'b1; TrapCause <= CAUSE_ILLEGAL;
          end
        S_JAL, S_LUI: state <= S_ALUWB;
        default:      state <= S_TRAP;
      endcase
    end
  end

  // Moore datapath controls; enables gated by MemRdy / branch outcome, and
  // everything held low while reset is asserted so MemReq drops immediately.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = IMM_I;
    alu3      = ALU_ADD;
    if (rst) begin
      case (state)
        S_FETCH: begin
          MemReq = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
          IRWrite = MemRdy; PCWrite = MemRdy;
        end
        S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; ImmSrc = IMM_B; end
        S_MEMADR: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD:  begin MemReq = 1'b1; AdrSrc = 1'b1; end
        S_MEMWB:    begin RegWrite = 1'b1; ResultSrc = 2'b01; end
        S_MEMWRITE: begin MemReq = 1'b1; MemWrite = 1'b1; AdrSrc = 1'b1; end
        S_EXECR:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b00; alu3 = exec_alu; end
        S_EXECI: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = IMM_I; alu3 = exec_alu;
        end
        S_ALUWB:    RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b00; alu3 = ALU_SUB; PCWrite = br_take;
        end
        S_JAL: begin
          ImmSrc = IMM_J; ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1;
        end
        S_LUI:      begin ImmSrc = IMM_U; ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
        default:    ;
      endcase
    end
  end

  assign ALUControl = ALUCTRL_W'(alu3);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed scenarios plus randomized
// instruction streams against an instruction-level reference model.
module tb_mc_ctrl_fsm;

  localparam int ALUW = 4;   // wider than 3 so upper ALUControl bits are checked
  localparam int CW   = 4;   // narrow counter so wrap-around is reached
  localparam int MTO  = 15;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [6:0]      op = 7'd0;
  logic [2:0]      funct3 = 3'd0;
  logic            funct7b5 = 1'b0;
  logic            Zero = 1'b0;
  logic            MemRdy = 1'b0;
  logic            MemReq, MemWrite, AdrSrc, PCWrite, IRWrite, RegWrite;
  logic [1:0]      ResultSrc, ALUSrcA, ALUSrcB, TrapCause;
  logic [2:0]      ImmSrc;
  logic [ALUW-1:0] ALUControl;
  logic            Trap;
  logic [CW-1:0]   InstRet;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALUCTRL_W(ALUW), .CNT_W(CW), .MEM_TIMEOUT(MTO)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemRdy(MemRdy), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Trap(Trap), .TrapCause(TrapCause), .InstRet(InstRet)
  );

  typedef struct {
    logic memreq, memwrite, adrsrc, pcwrite, irwrite, regwrite;
    logic [1:0] resultsrc, srca, srcb;
    logic [2:0] immsrc;
    logic [ALUW-1:0] alu;
  } samp_t;

  typedef struct {
    int cycles;
    bit trap;
    int n_reg, n_pc, n_memreq, n_memwrite;
    logic [1:0] wb_src;
    bit chk_x;
    logic [ALUW-1:0] alu_x;
    logic [1:0] srcb_x;
  } exp_t;

  samp_t       smp [64];
  int          tests = 0;
  int          fails = 0;
  int unsigned exp_ret = 0;
  int          wq[$];
  int          acc_cnt = 0;

  function automatic bit is_legal_op(input logic [6:0] o);
    return o == OP_LOAD || o == OP_STORE || o == OP_R || o == OP_I ||
           o == OP_BR || o == OP_JAL || o == OP_LUI;
  endfunction

  // Instruction-level expectations: cycle count until back in FETCH (or in
  // TRAP), enable pulse counts, and the ALU setup of the cycle after DECODE.
  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z,
                                 input int fw, input int mw);
    exp_t e;
    e.cycles = fw + 4; e.trap = 0; e.n_reg = 0; e.n_pc = 1;
    e.n_memreq = fw + 1; e.n_memwrite = 0; e.wb_src = 2'b00;
    e.chk_x = 1; e.alu_x = '0; e.srcb_x = 2'b01;
    case (o)
      OP_LOAD: begin
        e.cycles = fw + mw + 5; e.n_reg = 1; e.wb_src = 2'b01;
        e.n_memreq = fw + mw + 2;
      end
      OP_STORE: begin
        e.cycles = fw + mw + 4; e.n_memreq = fw + mw + 2; e.n_memwrite = mw + 1;
      end
      OP_R, OP_I: begin
        e.n_reg = 1;
        e.srcb_x = (o == OP_R) ? 2'b00 : 2'b01;
        case (f3)
          3'd0: e.alu_x = (o == OP_R && f7) ? ALUW'(1) : ALUW'(0);
          3'd2: e.alu_x = ALUW'(5);
          3'd4: e.alu_x = ALUW'(4);
          3'd6: e.alu_x = ALUW'(3);
          3'd7: e.alu_x = ALUW'(2);
          default: begin e.trap = 1; e.cycles = fw + 3; e.n_reg = 0; e.chk_x = 0; end
        endcase
      end
      OP_BR: begin
        e.cycles = fw + 3; e.srcb_x = 2'b00; e.alu_x = ALUW'(1);
        if (f3 == 3'd0)      e.n_pc = z ? 2 : 1;
        else if (f3 == 3'd1) e.n_pc = z ? 1 : 2;
        else begin e.trap = 1; e.chk_x = 0; end
      end
      OP_JAL: begin e.n_pc = 2; e.n_reg = 1; e.srcb_x = 2'b10; end
      OP_LUI: e.n_reg = 1;
      default: begin e.trap = 1; e.cycles = fw + 2; e.chk_x = 0; end
    endcase
    return e;
  endfunction

  // Memory responder: each access completes after its queued wait count;
  // MemRdy is randomized while no request is pending.
  task automatic drive_mem();
    if (MemReq) begin
      MemRdy = (wq.size() == 0) || (acc_cnt >= wq[0]);
      if (MemRdy) begin
        acc_cnt = 0;
        if (wq.size() != 0) void'(wq.pop_front());
      end else acc_cnt++;
    end else MemRdy = 1'($urandom_range(0, 1));
  endtask

  // Reset mid-cycle, check the reset state, release just after a rising edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (InstRet !== '0 || Trap !== 1'b0 || TrapCause !== 2'b00 || MemReq !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: InstRet=%0d Trap=%b TrapCause=%b MemReq=%b want 0/0/00/0",
               InstRet, Trap, TrapCause, MemReq);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if (MemReq !== 1'b1 || InstRet !== '0) begin
      fails++;
      $display("FAIL reset_release: MemReq=%b InstRet=%0d want 1/0", MemReq, InstRet);
    end
    exp_ret = 0; acc_cnt = 0; wq.delete();
  endtask

  // Run one instruction from FETCH; assumes the DUT is in FETCH just after an edge.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw, input string tag);
    exp_t e;
    int n_reg, n_pc, n_ir, n_mq, n_mw;
    bit wb_bad;
    e = model(o, f3, f7, z, fw, mw);
    n_reg = 0; n_pc = 0; n_ir = 0; n_mq = 0; n_mw = 0; wb_bad = 0;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    wq.push_back(fw);
    if (o == OP_LOAD || o == OP_STORE) wq.push_back(mw);
    for (int i = 0; i < e.cycles; i++) begin
      @(negedge clk);
      drive_mem();
      #1;
      if (i < 64) begin
        smp[i].memreq = MemReq;   smp[i].memwrite = MemWrite; smp[i].adrsrc = AdrSrc;
        smp[i].pcwrite = PCWrite; smp[i].irwrite = IRWrite;   smp[i].regwrite = RegWrite;
        smp[i].resultsrc = ResultSrc; smp[i].srca = ALUSrcA;  smp[i].srcb = ALUSrcB;
        smp[i].immsrc = ImmSrc;   smp[i].alu = ALUControl;
      end
      if (RegWrite) n_reg++;
      if (PCWrite)  n_pc++;
      if (IRWrite)  n_ir++;
      if (MemReq)   n_mq++;
      if (MemWrite) n_mw++;
      if (RegWrite && ResultSrc !== e.wb_src) wb_bad = 1;
    end
    @(posedge clk);
    #1;
    if (!e.trap) exp_ret++;
    tests++;
    if (n_reg != e.n_reg) begin fails++; $display("FAIL %s regwrite_count: got %0d want %0d", tag, n_reg, e.n_reg); end
    tests++;
    if (n_pc != e.n_pc) begin fails++; $display("FAIL %s pcwrite_count: got %0d want %0d", tag, n_pc, e.n_pc); end
    tests++;
    if (n_ir != 1) begin fails++; $display("FAIL %s irwrite_count: got %0d want 1", tag, n_ir); end
    tests++;
    if (n_mq != e.n_memreq) begin fails++; $display("FAIL %s memreq_cycles: got %0d want %0d", tag, n_mq, e.n_memreq); end
    tests++;
    if (n_mw != e.n_memwrite) begin fails++; $display("FAIL %s memwrite_cycles: got %0d want %0d", tag, n_mw, e.n_memwrite); end
    if (e.n_reg > 0) begin
      tests++;
      if (wb_bad) begin fails++; $display("FAIL %s wb_resultsrc: wrong value during RegWrite, want %b", tag, e.wb_src); end
    end
    if (e.chk_x && fw + 2 < 64) begin
      tests++;
      if (smp[fw+2].alu !== e.alu_x) begin fails++; $display("FAIL %s alucontrol: got %0d want %0d", tag, smp[fw+2].alu, e.alu_x); end
      tests++;
      if (smp[fw+2].srcb !== e.srcb_x) begin fails++; $display("FAIL %s alusrcb: got %b want %b", tag, smp[fw+2].srcb, e.srcb_x); end
    end
    tests++;
    if (InstRet !== CW'(exp_ret)) begin fails++; $display("FAIL %s instret: got %0d want %0d", tag, InstRet, CW'(exp_ret)); end
    tests++;
    if (Trap !== e.trap) begin fails++; $display("FAIL %s trap: got %b want %b", tag, Trap, e.trap); end
    if (e.trap) begin
      tests++;
      if (TrapCause !== 2'b01 || MemReq !== 1'b0) begin
        fails++; $display("FAIL %s trap_state: cause=%b MemReq=%b want 01/0", tag, TrapCause, MemReq);
      end
    end else begin
      tests++;
      if ({MemReq, AdrSrc, MemWrite, ALUSrcB} !== 5'b10010) begin
        fails++; $display("FAIL %s back_to_fetch: got %b want 10010", tag, {MemReq, AdrSrc, MemWrite, ALUSrcB});
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({MemReq, MemWrite, AdrSrc, PCWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
         ALUSrcB, ImmSrc, ALUControl} !== '0 || InstRet !== '0 || Trap !== 1'b0 ||
        TrapCause !== 2'b00) begin
      fails++; $display("FAIL reset_outputs: some output nonzero during reset (InstRet=%0d Trap=%b)", InstRet, Trap);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    MemRdy = 1'b0;
    #1;
    tests++;
    if ({MemReq, AdrSrc, PCWrite, IRWrite, ALUSrcB, ResultSrc} !== 8'b10001010) begin
      fails++; $display("FAIL fetch_wait: got %b want 10001010", {MemReq, AdrSrc, PCWrite, IRWrite, ALUSrcB, ResultSrc});
    end
    @(negedge clk);
    MemRdy = 1'b0;
    #1;
    tests++;
    if (MemReq !== 1'b1 || AdrSrc !== 1'b0) begin
      fails++; $display("FAIL fetch_hold: MemReq=%b AdrSrc=%b want 1/0", MemReq, AdrSrc);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (MemReq !== 1'b0) begin fails++; $display("FAIL async_drop: MemReq=%b want 0", MemReq); end
    do_reset();
  endtask

  task automatic test_addi();
    run_instr(OP_I, 3'b000, 1'b0, 1'b0, 0, 0, "addi");
    tests++;
    if ({smp[0].irwrite, smp[0].pcwrite, smp[0].srcb, smp[0].resultsrc} !== 6'b111010) begin
      fails++; $display("FAIL addi_fetch: got %b want 111010", {smp[0].irwrite, smp[0].pcwrite, smp[0].srcb, smp[0].resultsrc});
    end
    tests++;
    if ({smp[1].srca, smp[1].srcb, smp[1].immsrc} !== 7'b0101010) begin
      fails++; $display("FAIL addi_decode: got %b want 0101010", {smp[1].srca, smp[1].srcb, smp[1].immsrc});
    end
    tests++;
    if ({smp[2].srca, smp[2].regwrite, smp[3].regwrite, smp[3].resultsrc} !== 6'b100100) begin
      fails++; $display("FAIL addi_exec_wb: got %b want 100100", {smp[2].srca, smp[2].regwrite, smp[3].regwrite, smp[3].resultsrc});
    end
  endtask

  task automatic test_mem();
    bit bad;
    run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 3, "lw");
    bad = 0;
    for (int i = 3; i <= 6; i++)
      if (!smp[i].memreq || !smp[i].adrsrc || smp[i].regwrite) bad = 1;
    tests++;
    if (bad || smp[2].immsrc !== 3'b000 || smp[2].srca !== 2'b10) begin
      fails++; $display("FAIL lw_wait: memread not held 4 cycles or memadr setup wrong (immsrc=%b)", smp[2].immsrc);
    end
    tests++;
    if ({smp[7].regwrite, smp[7].resultsrc} !== 3'b101) begin
      fails++; $display("FAIL lw_memwb: got %b want 101", {smp[7].regwrite, smp[7].resultsrc});
    end
    run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 1, 2, "sw");
    bad = 0;
    for (int i = 4; i <= 6; i++)
      if (!smp[i].memwrite || !smp[i].adrsrc) bad = 1;
    tests++;
    if (bad || smp[3].immsrc !== 3'b001) begin
      fails++; $display("FAIL sw_setup: immsrc=%b want 001 or write not held", smp[3].immsrc);
    end
  endtask

  task automatic test_branch();
    run_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, "beq_z1");
    tests++;
    if (smp[2].pcwrite !== 1'b1) begin fails++; $display("FAIL beq_taken: pcwrite=%b want 1", smp[2].pcwrite); end
    run_instr(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0, "bne_z1");
    tests++;
    if (smp[2].pcwrite !== 1'b0) begin fails++; $display("FAIL bne_not_taken: pcwrite=%b want 0", smp[2].pcwrite); end
    run_instr(OP_BR, 3'b001, 1'b0, 1'b0, 2, 0, "bne_z0");
  endtask

  task automatic test_jal_lui();
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, "jal");
    tests++;
    if ({smp[2].pcwrite, smp[2].immsrc, smp[2].srca, smp[3].regwrite, smp[3].resultsrc} !== 9'b101101100) begin
      fails++; $display("FAIL jal_seq: got %b want 101101100",
                        {smp[2].pcwrite, smp[2].immsrc, smp[2].srca, smp[3].regwrite, smp[3].resultsrc});
    end
    run_instr(OP_LUI, 3'b101, 1'b1, 1'b0, 0, 0, "lui");
    tests++;
    if ({smp[2].immsrc, smp[2].srca, smp[2].srcb} !== 7'b1001101) begin
      fails++; $display("FAIL lui_setup: got %b want 1001101", {smp[2].immsrc, smp[2].srca, smp[2].srcb});
    end
  endtask

  task automatic test_trap();
    int bad;
    run_instr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0, "illegal_7f");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      MemRdy = 1'($urandom_range(0, 1));
      #1;
      if (MemReq !== 1'b0 || Trap !== 1'b1 || TrapCause !== 2'b01) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL trap_hold: %0d bad cycles want 0", bad); end
    do_reset();
    run_instr(OP_R, 3'b011, 1'b0, 1'b0, 0, 0, "r_bad_f3");
    do_reset();
    run_instr(OP_BR, 3'b100, 1'b0, 1'b1, 1, 0, "br_bad_f3");
    do_reset();
  endtask

  task automatic test_timeout();
`ifdef MC_MEM_TIMEOUT_EN
    int n;
    bit done;
    n = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      MemRdy = 1'b0;
      #1;
      if (Trap) done = 1;
      else if (MemReq) n++;
    end
    tests++;
    if (!done || n != MTO || TrapCause !== 2'b10) begin
      fails++; $display("FAIL mem_timeout: trapped=%b waits=%0d cause=%b want 1/%0d/10", done, n, TrapCause, MTO);
    end
    do_reset();
    run_instr(OP_I, 3'b000, 1'b0, 1'b0, MTO - 1, 0, "rdy_at_limit");
`else
    run_instr(OP_I, 3'b000, 1'b0, 1'b0, 40, 0, "long_wait");
`endif
  endtask

  task automatic test_back_to_back();
    int lf[5] = '{0, 2, 4, 6, 7};
    for (int k = 0; k < 20; k++)
      run_instr((k % 2) ? OP_R : OP_I, 3'(lf[$urandom_range(0, 4)]),
                1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3), 0, "b2b");
  endtask

  task automatic test_random();
    int lf[5] = '{0, 2, 4, 6, 7};
    logic [6:0] o;
    logic [2:0] f3;
    int kind;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      case (kind)
        0: o = OP_LOAD;
        1: o = OP_STORE;
        2: begin o = OP_R; f3 = 3'(lf[$urandom_range(0, 4)]); end
        3: begin o = OP_I; f3 = 3'(lf[$urandom_range(0, 4)]); end
        4: begin o = OP_BR; f3 = 3'($urandom_range(0, 1)); end
        5: o = OP_JAL;
        6: o = OP_LUI;
        7: do o = 7'($urandom_range(0, 127)); while (is_legal_op(o));
        8: o = ($urandom_range(0, 1) != 0) ? OP_R : OP_I;
        default: o = OP_BR;
      endcase
      run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), "random");
      if (Trap) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_mem();
    test_branch();
    test_jal_lui();
    test_trap();
    test_timeout();
    do_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
